// File: rtl/display_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller_pkg
// Purpose  : Shared constants, types and helper functions for the display
//            scan controller. This includes the BCD digit vector, the
//            conversion FSM state type, the add-3 correction and the
//            leading-zero test.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package display_scan_controller_pkg;

  localparam int DIGITS    = 4;
  localparam int VALUE_W   = 14;
  localparam int MAX_VALUE = 9999;
  localparam int BCD_W     = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Element 0 holds the units digit.
  typedef logic [DIGITS-1:0][3:0] bcd4_t;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic bcd4_t add3(input bcd4_t a);
    bcd4_t r;
    r = a;
    for (int j = 0; j < DIGITS; j++) begin
      if (a[j] >= 4'd5) r[j] = a[j] + 4'd3;
    end
    return r;
  endfunction

  // True when digit idx is a leading zero. This means idx is above the units
  // position and every digit from idx up to the top digit is zero.
  function automatic logic blank_digit(input bcd4_t shown, input logic [1:0] idx);
    logic blank;
    blank = (idx != 2'd0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && (shown[j] != 4'd0)) blank = 1'b0;
    end
    return blank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller_if
// Purpose  : Bundles the value/load handshake and the display outputs of the
//            scan controller.
// Ports    : value, load, display_on        (producer -> controller)
//            busy, done, overflow           (controller -> producer)
//            digit, digit_en, anode         (controller -> decoder/pins)
//            master = producer side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface display_scan_controller_if;
  import display_scan_controller_pkg::*;

  logic [VALUE_W-1:0] value;
  logic               load;
  logic               display_on;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [3:0]         digit;
  logic               digit_en;
  logic [3:0]         anode;

  modport master (
    output value, load, display_on,
    input  busy, done, overflow, digit, digit_en, anode
  );

  modport slave (
    input  value, load, display_on,
    output busy, done, overflow, digit, digit_en, anode
  );

endinterface
`default_nettype wire

// File: rtl/display_scan_controller_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential double-dabble converter that performs one
//            shift-add-3 step per clock. The finished BCD result is copied
//            atomically into the shown-digit register.
// Ports    : clk, rst      clock / async active-high reset
//            value, load   binary input and single-cycle capture request
//            busy          conversion in progress (loads ignored)
//            done          one-cycle pulse when shown digits update
//            overflow      last accepted value was saturated to 9999
//            shown         digits currently visible on the display
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import display_scan_controller_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [VALUE_W-1:0] value,
  input  wire logic               load,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output bcd4_t                   shown
);

  localparam logic [VALUE_W-1:0] C_MAX_VALUE = VALUE_W'(MAX_VALUE);
  localparam logic [3:0]         C_LAST_ITER = 4'(VALUE_W - 1);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  bcd4_t              shown_q, shown_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_next;

  always_comb begin
    acc_adj  = add3(acc_q);
    acc_next = {acc_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    shown_d    = shown_q;
    case (state_q)
      // COMMIT is the cycle in which done is visible and busy is already
      // low, so it accepts a new load exactly like IDLE.
      ST_IDLE, ST_COMMIT: begin
        state_d = ST_IDLE;
        if (load) begin
          if (value > C_MAX_VALUE) begin
            bin_d      = C_MAX_VALUE;
            overflow_d = 1'b1;
          end else begin
            bin_d      = value;
            overflow_d = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_d = acc_next;
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        // The last iteration's result goes straight into the shown register
        // so the digits appear together with the done pulse.
        if (cnt_q == C_LAST_ITER) begin
          shown_d = bcd4_t'(acc_next);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_COMMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      shown_q    <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      shown_q    <= shown_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign shown    = shown_q;

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller
// Purpose  : Converts a binary value to four BCD digits and time-multiplexes
//            them onto one seven-segment decoder. Leading zeros can
//            optionally be blanked.
// Ports    : clk, rst   clock / async active-high reset
//            bus        slave side of display_scan_controller_if
//                       (value, load, display_on in; busy, done, overflow,
//                        digit, digit_en, anode out)
// Params   : REFRESH_DIV    clocks per digit slot (>= 2)
//            BLANK_LEADING  1 = suppress leading zeros
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  display_scan_controller_if.slave bus
);

  localparam int             PRE_W  = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] C_PRE_TC = PRE_W'(REFRESH_DIV - 1);

  logic             conv_busy;
  logic             conv_done;
  logic             conv_overflow;
  bcd4_t            shown;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_en_q, digit_en_d;
  logic [3:0]       anode_q, anode_d;

  bin_to_bcd_seq u_conv (
    .clk      (clk),
    .rst      (rst),
    .value    (bus.value),
    .load     (bus.load),
    .busy     (conv_busy),
    .done     (conv_done),
    .overflow (conv_overflow),
    .shown    (shown)
  );

  // The prescaler and scan index free-run regardless of display_on and
  // conversion activity.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == C_PRE_TC) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // The output stage samples the current index and shown digits. A COMMIT
  // that coincides with a scan advance is therefore seen by the new slot.
  always_comb begin
    digit_d    = shown[idx_q];
    anode_d    = 4'b1111;
    digit_en_d = 1'b0;
    if (bus.display_on) begin
      anode_d    = ~(4'b0001 << idx_q);
      digit_en_d = !(BLANK_LEADING && blank_digit(shown, idx_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      digit_q    <= '0;
      digit_en_q <= 1'b0;
      anode_q    <= 4'b1111;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      digit_en_q <= digit_en_d;
      anode_q    <= anode_d;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.done     = conv_done;
  assign bus.overflow = conv_overflow;
  assign bus.digit    = digit_q;
  assign bus.digit_en = digit_en_q;
  assign bus.anode    = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_controller
// Purpose  : Directed self-checking bench. Two instances with REFRESH_DIV=4
//            are driven with the same inputs: dut_a uses BLANK_LEADING=1 and
//            dut_b uses BLANK_LEADING=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  display_scan_controller_if bus_a ();
  display_scan_controller_if bus_b ();

  assign bus_b.value      = bus_a.value;
  assign bus_b.load       = bus_a.load;
  assign bus_b.display_on = bus_a.display_on;

  display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; used to model the scan position.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_load(input int v);
    @(negedge clk);
    bus_a.value = 14'(v);
    bus_a.load  = 1'b1;
    @(negedge clk);
    bus_a.load  = 1'b0;
  endtask

  // Called right after pulse_load; the first sample after acceptance is
  // cycle 1, so a correct design reports 15.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_slot(input bit sel_b, input int idx, input int dig, input bit en);
    logic [3:0] exp_an;
    logic [3:0] an;
    exp_an = ~(4'b0001 << idx);
    an     = 4'b0000;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      an = sel_b ? bus_b.anode : bus_a.anode;
      if (an === exp_an) break;
    end
    chk($sformatf("slot%0d_%s_anode", idx, sel_b ? "b" : "a"), {28'd0, an}, {28'd0, exp_an});
    chk($sformatf("slot%0d_%s_digit", idx, sel_b ? "b" : "a"),
        {28'd0, sel_b ? bus_b.digit : bus_a.digit}, 32'(dig));
    chk($sformatf("slot%0d_%s_en", idx, sel_b ? "b" : "a"),
        {31'd0, sel_b ? bus_b.digit_en : bus_a.digit_en}, {31'd0, en});
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    int eidx;
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus_a.value      = '0;
    bus_a.load       = 1'b0;
    bus_a.display_on = 1'b1;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_busy",     {31'd0, bus_a.busy},     32'd0);
    chk("rst_done",     {31'd0, bus_a.done},     32'd0);
    chk("rst_overflow", {31'd0, bus_a.overflow}, 32'd0);
    chk("rst_digit",    {28'd0, bus_a.digit},    32'd0);
    chk("rst_digit_en", {31'd0, bus_a.digit_en}, 32'd0);
    chk("rst_anode",    {28'd0, bus_a.anode},    32'hF);

    // ---- reset asserted while scanning takes effect immediately ----
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_anode",    {28'd0, bus_a.anode},    32'hF);
    chk("arst_digit_en", {31'd0, bus_a.digit_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- scan sequence after release: 4 clocks per slot, only units lit ----
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      eidx = (k - 1) / 4;
      chk($sformatf("scan%0d_anode", k), {28'd0, bus_a.anode}, {28'd0, ~(4'b0001 << eidx)});
      chk($sformatf("scan%0d_en", k), {31'd0, bus_a.digit_en}, (eidx == 0) ? 32'd1 : 32'd0);
      chk($sformatf("scan%0d_digit", k), {28'd0, bus_a.digit}, 32'd0);
    end

    // ---- 1234: busy for 14 cycles, done 15 cycles after acceptance ----
    pulse_load(1234);
    chk("c1234_busy_first", {31'd0, bus_a.busy}, 32'd1);
    nbusy = 0;
    ndone = 0;
    for (int i = 2; i <= 14; i++) begin
      @(negedge clk);
      if (bus_a.busy === 1'b1) nbusy++;
      if (bus_a.done === 1'b1) ndone++;
    end
    chk("c1234_busy_cycles", 32'(nbusy), 32'd13);
    chk("c1234_no_early_done", 32'(ndone), 32'd0);
    @(negedge clk);
    chk("c1234_done", {31'd0, bus_a.done}, 32'd1);
    chk("c1234_busy_low", {31'd0, bus_a.busy}, 32'd0);
    @(negedge clk);
    chk("c1234_done_pulse", {31'd0, bus_a.done}, 32'd0);
    chk("c1234_overflow", {31'd0, bus_a.overflow}, 32'd0);
    check_slot(1'b0, 0, 4, 1'b1);
    check_slot(1'b0, 1, 3, 1'b1);
    check_slot(1'b0, 2, 2, 1'b1);
    check_slot(1'b0, 3, 1, 1'b1);

    // ---- 7 with and without leading-zero blanking ----
    pulse_load(7);
    wait_done(lat);
    chk("c7_latency", 32'(lat), 32'd15);
    check_slot(1'b0, 0, 7, 1'b1);
    check_slot(1'b0, 1, 0, 1'b0);
    check_slot(1'b0, 2, 0, 1'b0);
    check_slot(1'b0, 3, 0, 1'b0);
    check_slot(1'b1, 0, 7, 1'b1);
    check_slot(1'b1, 1, 0, 1'b1);
    check_slot(1'b1, 2, 0, 1'b1);
    check_slot(1'b1, 3, 0, 1'b1);

    // ---- saturation and overflow boundaries ----
    pulse_load(12000);
    wait_done(lat);
    chk("c12000_overflow", {31'd0, bus_a.overflow}, 32'd1);
    check_slot(1'b0, 0, 9, 1'b1);
    check_slot(1'b0, 1, 9, 1'b1);
    check_slot(1'b0, 2, 9, 1'b1);
    check_slot(1'b0, 3, 9, 1'b1);
    pulse_load(9999);
    wait_done(lat);
    chk("c9999_overflow", {31'd0, bus_a.overflow}, 32'd0);
    pulse_load(10000);
    wait_done(lat);
    chk("c10000_overflow", {31'd0, bus_a.overflow}, 32'd1);
    pulse_load(0);
    wait_done(lat);
    chk("c0_overflow", {31'd0, bus_a.overflow}, 32'd0);
    check_slot(1'b0, 0, 0, 1'b1);
    check_slot(1'b0, 1, 0, 1'b0);
    check_slot(1'b0, 3, 0, 1'b0);

    // ---- load while busy is ignored ----
    pulse_load(5555);
    bus_a.value = 14'd42;
    bus_a.load  = 1'b1;
    @(negedge clk);
    bus_a.load  = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) ndone++;
    end
    chk("c5555_done_count", 32'(ndone), 32'd1);
    check_slot(1'b0, 0, 5, 1'b1);
    check_slot(1'b0, 1, 5, 1'b1);
    check_slot(1'b0, 2, 5, 1'b1);
    check_slot(1'b0, 3, 5, 1'b1);
    pulse_load(42);
    wait_done(lat);
    chk("c42_latency", 32'(lat), 32'd15);
    check_slot(1'b0, 0, 2, 1'b1);
    check_slot(1'b0, 1, 4, 1'b1);
    check_slot(1'b0, 2, 0, 1'b0);
    check_slot(1'b0, 3, 0, 1'b0);

    // ---- display_on=0 darkens the display while the scan keeps running ----
    @(negedge clk);
    bus_a.display_on = 1'b0;
    @(negedge clk);
    chk("off_anode", {28'd0, bus_a.anode}, 32'hF);
    chk("off_en", {31'd0, bus_a.digit_en}, 32'd0);
    repeat (7) @(negedge clk);
    chk("off_anode_held", {28'd0, bus_a.anode}, 32'hF);
    bus_a.display_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eidx = ((cyc - 1) / 4) % 4;
      chk($sformatf("on%0d_anode", k), {28'd0, bus_a.anode}, {28'd0, ~(4'b0001 << eidx)});
      chk($sformatf("on%0d_digit", k), {28'd0, bus_a.digit},
          (eidx == 0) ? 32'd2 : (eidx == 1) ? 32'd4 : 32'd0);
      chk($sformatf("on%0d_en", k), {31'd0, bus_a.digit_en}, (eidx <= 1) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Upstream stage of the seven-segment decoder. Accepts a binary value of up to 14 bits and converts it to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the four digits onto one decoder instance. Each refresh slot drives the decoder's digit code and enable inputs and the active-low anode select for one digit.
- Sits between the random-number core (producer) and the decoder/board pins.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays selected (minimum 2)
BLANK_LEADING, 1, 1 = suppress leading zeros; 0 = show all four digits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
value  input  14  binary number to display
load  input  1  single-cycle request to capture value
display_on  input  1  0 = all digits dark; scanning continues
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new digits become visible
overflow  output  1  last accepted value exceeded 9999
digit  output  4  BCD code to the decoder digit input
digit_en  output  1  to the decoder enable input
anode  output  4  active-low digit select; bit 0 = units

Behaviour:
- Interface: one clock domain on clk. rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - busy=0, done=0, overflow=0, digit=0, digit_en=0, anode=4'b1111.
  - Shown digits = 0000, scan index = 0, prescaler = 0.
- Load acceptance:
  - load is accepted only when busy=0.
  - load while busy=1 is ignored; no queueing.
- Saturation: an accepted value >9999 is replaced by 9999 and sets overflow=1. overflow is re-evaluated on every accepted load.
- Conversion FSM, states IDLE -> CONV -> COMMIT -> IDLE:
  - IDLE: on accepted load, capture the (saturated) value and clear the 16-bit BCD accumulator. Go to CONV; busy=1 from the next cycle.
  - CONV: one shift-add-3 iteration per clock, exactly 14 iterations. Before each shift, every BCD nibble >=5 gets +3.
  - COMMIT: copy the accumulator to the shown-digit register, pulse done=1 for one cycle, set busy=0 in the same cycle.
- Latency: load accepted at cycle N gives done and new digits at cycle N+15. The next load is accepted from cycle N+15.
- Tear-free display: shown digits change only in COMMIT, atomically.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count it wraps to 0 and the scan index advances 0->1->2->3->0.
- Output registers: updated on the clock after the index changes.
  - anode = ~(1<<index).
  - digit = shown[index].
  - digit_en = 1, except when BLANK_LEADING=1, index>0 and shown digits at positions index..3 are all zero; then digit_en = 0.
  - Units digit is never blanked, so value 0 shows "0".
- display_on=0:
  - Forces anode=4'b1111 and digit_en=0 at the next clock.
  - Prescaler, index and conversion continue unaffected.
- Simultaneous COMMIT and scan advance: the newly committed digits are used for the slot being entered.
- Reset mid-conversion: the conversion is aborted, shown digits return to 0000 and no done pulse is produced.

Decomposition:
- Shared package:
  - DIGITS=4, VALUE_W=14, MAX_VALUE=9999.
  - Typedef for the FSM state enum.
  - Typedef for bcd4_t (4x4-bit packed array).
- One sub-module is natural: bin_to_bcd_seq (FSM plus shift-add-3 datapath, with load/busy/done handshake). The top level keeps the prescaler, scan index, blanking and output registers.

Test Plan:
1. Reset while scanning (REFRESH_DIV=4) -> all outputs at reset values next edge. After release, anode cycles 1110,1101,1011,0111 every 4 clocks; digit_en=1 only on units with digit=0.
2. load value=1234 -> busy=1 for 14 cycles, done pulses 15 cycles after load. Then anode 1110/1101/1011/0111 shows digit 4/3/2/1, all digit_en=1, overflow=0.
3. load value=7 (BLANK_LEADING=1) -> units digit=7 with digit_en=1; tens, hundreds and thousands have digit_en=0. Repeat with BLANK_LEADING=0 -> digits 7,0,0,0 all enabled.
4. load value=12000 -> displays 9,9,9,9 and overflow=1. Then load 0 -> overflow=0, display "0".
5. load 5555, then load 42 two cycles later -> second load ignored, done once, display 5555. load 42 after done -> display 42 after 15 cycles.
6. display_on=0 mid-scan -> anode=1111 and digit_en=0 next clock while index keeps advancing. display_on=1 -> resumes at the current index with correct digit.
